// File: rtl/vx_mshr_pf_sched_pkg.sv
// Shared defaults and helpers for the MSHR allocate-port scheduler.
// Covers the demand/prefetch arbitration between the bank pipeline and the bank MSHR.
package vx_mshr_pf_sched_pkg;
  localparam int DEF_MSHR_SIZE       = 4;
  localparam int DEF_LINE_ADDR_WIDTH = 26;
  localparam int DEF_MSHR_DATA_WIDTH = 32;
  localparam int DEF_PF_QUEUE_SIZE   = 4;
  localparam int DEF_MAX_PF_INFLIGHT = 2;
  localparam int DEF_STARVE_LIMIT    = 8;

  localparam logic [15:0] PERF_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == PERF_SAT) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/vx_mshr_pf_sched_fifo.sv
// Prefetch candidate FIFO with a combinational head, so the head address can drive
// the MSHR probe in the same cycle it becomes visible.
module vx_mshr_pf_sched_fifo #(
  parameter int DATAW = 26,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DATAW-1:0] i_data,
  output logic [DATAW-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(SIZE);

  logic [DATAW-1:0] r_mem [SIZE];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(SIZE));
endmodule

// File: rtl/vx_mshr_pf_sched.sv
// Per-bank MSHR allocate scheduler: arbitrates demand misses against queued prefetches,
// drops prefetches already pending in the MSHR and caps prefetch-owned MSHR entries.
module vx_mshr_pf_sched
  import vx_mshr_pf_sched_pkg::*;
#(
  parameter int MSHR_SIZE       = DEF_MSHR_SIZE,
  parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
  parameter int MSHR_DATA_WIDTH = DEF_MSHR_DATA_WIDTH,
  parameter int PF_QUEUE_SIZE   = DEF_PF_QUEUE_SIZE,
  parameter int MAX_PF_INFLIGHT = DEF_MAX_PF_INFLIGHT,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT,
  localparam int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE),
  localparam int PFW             = $clog2(MAX_PF_INFLIGHT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_pf_enable,
  input  logic                       i_dmd_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] i_dmd_addr,
  input  logic [MSHR_DATA_WIDTH-1:0] i_dmd_data,
  output logic                       o_dmd_ready,
  input  logic                       i_pf_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] i_pf_addr,
  output logic                       o_pf_ready,
  output logic [LINE_ADDR_WIDTH-1:0] o_probe_addr,
  input  logic                       i_probe_match,
  output logic                       o_alloc_valid,
  output logic [LINE_ADDR_WIDTH-1:0] o_alloc_addr,
  output logic [MSHR_DATA_WIDTH-1:0] o_alloc_data,
  input  logic [MSHR_ADDR_WIDTH-1:0] i_alloc_id,
  input  logic                       i_alloc_ready,
  input  logic                       i_release_valid,
  input  logic [MSHR_ADDR_WIDTH-1:0] i_release_id,
  output logic [PFW-1:0]             o_pf_inflight,
  output logic [15:0]                o_perf_pf_drops
);
  localparam int STW = $clog2(STARVE_LIMIT + 1);

  logic [MSHR_SIZE-1:0]       r_owned;
  logic [PFW-1:0]             r_pf_inflight;
  logic [STW-1:0]             r_starve_cnt;
  logic [15:0]                r_pf_drops;
  logic [MSHR_SIZE-1:0]       w_owned_next;
  logic [LINE_ADDR_WIDTH-1:0] w_head;
  logic                       w_empty, w_full;
  logic                       w_push, w_pop, w_dup, w_eligible, w_pf_sel;
  logic                       w_pf_fire, w_dmd_fire, w_rel_hit;

  vx_mshr_pf_sched_fifo #(
    .DATAW (LINE_ADDR_WIDTH),
    .SIZE  (PF_QUEUE_SIZE)
  ) u_pf_queue (
    .clk     (clk),
    .reset   (reset),
    .i_flush (!i_pf_enable),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_pf_addr),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Duplicates are only dropped while enabled; a disabled queue is flushed without counting.
  assign w_dup      = !w_empty && i_pf_enable && i_probe_match;
  assign w_eligible = !w_empty && i_pf_enable && !i_probe_match
                      && (r_pf_inflight < PFW'(MAX_PF_INFLIGHT));
  assign w_pf_sel   = w_eligible && (!i_dmd_valid || (r_starve_cnt == STW'(STARVE_LIMIT)));
  assign w_pf_fire  = w_pf_sel && i_alloc_ready;
  assign w_dmd_fire = i_dmd_valid && o_dmd_ready;
  assign w_pop      = w_pf_fire || w_dup;
  assign w_push     = i_pf_valid && o_pf_ready;
  assign w_rel_hit  = i_release_valid && r_owned[i_release_id];

  assign o_pf_ready      = i_pf_enable && !w_full;
  assign o_dmd_ready     = i_dmd_valid && i_alloc_ready && !w_pf_sel;
  assign o_alloc_valid   = i_dmd_valid || w_eligible;
  assign o_alloc_addr    = w_pf_sel ? w_head : i_dmd_addr;
  assign o_alloc_data    = w_pf_sel ? {{(MSHR_DATA_WIDTH-1){1'b0}}, 1'b1}
                                    : {i_dmd_data[MSHR_DATA_WIDTH-1:1], 1'b0};
  assign o_probe_addr    = w_head;
  assign o_pf_inflight   = r_pf_inflight;
  assign o_perf_pf_drops = r_pf_drops;

  // Release clears before the new prefetch sets, so a recycled id ends up owned.
  always_comb begin
    w_owned_next = r_owned;
    if (w_rel_hit) w_owned_next[i_release_id] = 1'b0;
    if (w_pf_fire) w_owned_next[i_alloc_id]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owned       <= '0;
      r_pf_inflight <= '0;
      r_starve_cnt  <= '0;
      r_pf_drops    <= '0;
    end else begin
      r_owned <= w_owned_next;
      case ({w_pf_fire, w_rel_hit})
        2'b10:   r_pf_inflight <= r_pf_inflight + PFW'(1);
        2'b01:   r_pf_inflight <= r_pf_inflight - PFW'(1);
        default: r_pf_inflight <= r_pf_inflight;
      endcase
      if (w_pf_fire || !w_eligible) begin
        r_starve_cnt <= '0;
      end else if (w_dmd_fire && (r_starve_cnt != STW'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + STW'(1);
      end
      if (w_dup) r_pf_drops <= sat_inc16(r_pf_drops);
    end
  end

  a_no_release_underflow: assert property (@(posedge clk) disable iff (reset)
    !(w_rel_hit && (r_pf_inflight == '0)));
endmodule
